// File: rtl/main_fsm.sv
// main_fsm: multicycle RISC-V main control FSM.
// Steps each instruction through Fetch/Decode/Execute/Memory/Writeback,
// produces the Moore-type enables and mux selects for the datapath
// (all except ImmSrc and ALUControl) and counts retired instructions.
// Optional feature macro: MAIN_FSM_MEM_READY_EN adds a mem_ready input that
// stalls FETCH, MEMREAD and MEMWR and masks the writes issued in them.
module main_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       op,
`ifdef MAIN_FSM_MEM_READY_EN
  input  logic             mem_ready,
`endif
  output logic             PCUpdate,
  output logic             Branch,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             AdrSrc,
  output logic [1:0]       ALUOp,
  output logic             illegal_instr,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMREAD = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXER    = 4'd7,
    S_EXEI    = 4'd8,
    S_ALUWB   = 4'd9,
    S_BEQ     = 4'd10,
    S_JAL     = 4'd11,
    S_ILLEGAL = 4'd15
  } state_t;

  // Opcodes understood by the sequencer.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Mux select encodings.
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_DATA    = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_WDATA  = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;
  logic             mem_rdy;

  // Without the handshake the memory is treated as always ready.
`ifdef MAIN_FSM_MEM_READY_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // State and retired-instruction counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_RST;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and Moore output decode; outputs depend only on the state
  // (and on mem_ready for stall masking), never on op.
  always_comb begin
    state_d       = state_q;
    retire        = 1'b0;
    PCUpdate      = 1'b0;
    Branch        = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = RES_ALUOUT;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_WDATA;
    AdrSrc        = 1'b0;
    ALUOp         = ALUOP_ADD;
    illegal_instr = 1'b0;

    case (state_q)
      S_RST: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        // PC+4 computed on the ALU while the instruction is read at PC.
        IRWrite   = mem_rdy;
        PCUpdate  = mem_rdy;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALURES;
        if (mem_rdy) begin
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively form OldPC + imm as a branch/jump target.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXER;
          OP_ITYPE:          state_d = S_EXEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_ILLEGAL;
        endcase
      end

      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_ADD;
        if (op == OP_LOAD) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWR;
        end
      end

      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        if (mem_rdy) begin
          state_d = S_MEMWB;
        end
      end

      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_MEMWR: begin
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemWrite  = mem_rdy;
        if (mem_rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_WDATA;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end

      S_EXEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end

      S_JAL: begin
        // Jump to the target formed in DECODE; ALU produces OldPC+4 as link.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALUOP_ADD;
        ResultSrc = RES_ALUOUT;
        PCUpdate  = 1'b1;
        state_d   = S_ALUWB;
      end

      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_BEQ: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_WDATA;
        ALUOp     = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        Branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end

      S_ILLEGAL: begin
        // Parked with every enable low until reset.
        illegal_instr = 1'b1;
        state_d       = S_ILLEGAL;
      end

      default: begin
        // Unused encodings recover to FETCH with all outputs low.
        state_d = S_FETCH;
      end
    endcase
  end

  // Retired-instruction counter; wraps naturally at 2^CNT_W.
  always_comb begin
    instret_d = instret_q;
    if (retire) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_main_fsm.sv
// tb_main_fsm: directed-vector bench for main_fsm (CNT_W=4 to exercise wrap).
module tb_main_fsm;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset_n;
  logic [6:0]       op;
`ifdef MAIN_FSM_MEM_READY_EN
  logic             mem_ready;
`endif
  logic             PCUpdate, Branch, RegWrite, MemWrite, IRWrite, AdrSrc;
  logic             illegal_instr;
  logic [1:0]       ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  int               n_chk;
  int               n_pass;
  logic [3:0]       exp_ir;

  main_fsm #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op           (op),
`ifdef MAIN_FSM_MEM_READY_EN
    .mem_ready    (mem_ready),
`endif
    .PCUpdate     (PCUpdate),
    .Branch       (Branch),
    .RegWrite     (RegWrite),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .AdrSrc       (AdrSrc),
    .ALUOp        (ALUOp),
    .illegal_instr(illegal_instr),
    .state        (state),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: PCU,Br,RW,MW,IRW,RS[2],SA[2],SB[2],Adr,AO[2],ill
  logic [14:0] obs;
  assign obs = {PCUpdate, Branch, RegWrite, MemWrite, IRWrite, ResultSrc,
                ALUSrcA, ALUSrcB, AdrSrc, ALUOp, illegal_instr};

  // Hand-written expected output bundle per state.
  function automatic logic [14:0] exp_out(input logic [3:0] s);
    case (s)
      4'd1:    return 15'b1_0_0_0_1_10_00_10_0_00_0;
      4'd2:    return 15'b0_0_0_0_0_00_01_01_0_00_0;
      4'd3:    return 15'b0_0_0_0_0_00_10_01_0_00_0;
      4'd4:    return 15'b0_0_0_0_0_00_00_00_1_00_0;
      4'd5:    return 15'b0_0_1_0_0_01_00_00_0_00_0;
      4'd6:    return 15'b0_0_0_1_0_00_00_00_1_00_0;
      4'd7:    return 15'b0_0_0_0_0_00_10_00_0_10_0;
      4'd8:    return 15'b0_0_0_0_0_00_10_01_0_10_0;
      4'd9:    return 15'b0_0_1_0_0_00_00_00_0_00_0;
      4'd10:   return 15'b0_1_0_0_0_00_10_00_0_01_0;
      4'd11:   return 15'b1_0_0_0_0_00_01_10_0_00_0;
      4'd15:   return 15'b0_0_0_0_0_00_00_00_0_00_1;
      default: return 15'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run one instruction from FETCH. seq holds the n states after FETCH,
  // first state in the low nibble; the last one must be FETCH again.
  task automatic do_instr(input string name, input logic [6:0] o,
                          input int n, input logic [23:0] seq);
    logic [3:0] s;
    op = o;
    chk({name, " fetch state"}, 32'(state), 32'd1);
    chk({name, " fetch outs"}, 32'(obs), 32'(exp_out(4'd1)));
    for (int i = 0; i < n; i++) begin
      cyc();
      s = seq[4*i +: 4];
      if (i == n - 1) exp_ir = exp_ir + 4'd1;
      chk($sformatf("%s state%0d", name, i), 32'(state), 32'(s));
      chk($sformatf("%s outs%0d", name, i), 32'(obs), 32'(exp_out(s)));
      chk($sformatf("%s instret%0d", name, i), 32'(instret), 32'(exp_ir));
      // op is only looked at in DECODE/MEMADR; disturb it elsewhere.
      if (s != 4'd2 && s != 4'd3) op = ~o;
    end
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    exp_ir  = 4'd0;
    op      = 7'b0110011;
    reset_n = 1'b1;
`ifdef MAIN_FSM_MEM_READY_EN
    mem_ready = 1'b1;
`endif
    #2 reset_n = 1'b0;
    cyc();
    cyc();
    chk("rst state", 32'(state), 32'd0);
    chk("rst outs", 32'(obs), 32'd0);
    chk("rst instret", 32'(instret), 32'd0);

    // Release reset away from the edge; RST -> FETCH on the next edge.
    reset_n = 1'b1;
    cyc();

    do_instr("rtype", 7'b0110011, 4, 24'h001972);
    do_instr("lw",    7'b0000011, 5, 24'h015432);
    do_instr("sw",    7'b0100011, 4, 24'h001632);
    do_instr("beq",   7'b1100011, 3, 24'h0001A2);
    do_instr("jal",   7'b1101111, 4, 24'h0019B2);
    do_instr("itype", 7'b0010011, 4, 24'h001982);

    // Illegal opcode parks the FSM with the counter frozen.
    op = 7'b1111111;
    cyc();
    chk("ill decode", 32'(state), 32'd2);
    cyc();
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("ill state%0d", i), 32'(state), 32'd15);
      chk($sformatf("ill outs%0d", i), 32'(obs), 32'(exp_out(4'd15)));
      chk($sformatf("ill instret%0d", i), 32'(instret), 32'(exp_ir));
      cyc();
    end

    // Asynchronous reset mid-cycle takes effect before the next edge.
    #1 reset_n = 1'b0;
    #1;
    chk("async state", 32'(state), 32'd0);
    chk("async instret", 32'(instret), 32'd0);
    chk("async outs", 32'(obs), 32'd0);
    cyc();
    reset_n = 1'b1;
    exp_ir  = 4'd0;
    cyc();

    // Fill the 4-bit counter to 15, then one beq wraps it to 0.
    for (int k = 0; k < 15; k++) begin
      do_instr($sformatf("fill%0d", k), 7'b0110011, 4, 24'h001972);
    end
    chk("instret max", 32'(instret), 32'd15);
    do_instr("wrap beq", 7'b1100011, 3, 24'h0001A2);
    chk("instret wrap", 32'(instret), 32'd0);

`ifdef MAIN_FSM_MEM_READY_EN
    // FETCH stall: no IRWrite/PCUpdate until ready, then a single pulse.
    mem_ready = 1'b0;
    op = 7'b0100011;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall fetch state%0d", i), 32'(state), 32'd1);
      chk($sformatf("stall irwrite%0d", i), 32'(IRWrite), 32'd0);
      chk($sformatf("stall pcupdate%0d", i), 32'(PCUpdate), 32'd0);
      cyc();
    end
    mem_ready = 1'b1;
    #1;
    chk("ready irwrite", 32'(IRWrite), 32'd1);
    cyc();
    chk("ready decode", 32'(state), 32'd2);
    chk("post irwrite", 32'(IRWrite), 32'd0);
    cyc();
    cyc();
    // MEMWR stall: no MemWrite and no retire until ready.
    mem_ready = 1'b0;
    #1;
    chk("stall memwr state", 32'(state), 32'd6);
    chk("stall memwrite", 32'(MemWrite), 32'd0);
    cyc();
    chk("stall memwr hold", 32'(state), 32'd6);
    chk("stall instret", 32'(instret), 32'd0);
    mem_ready = 1'b1;
    #1;
    chk("ready memwrite", 32'(MemWrite), 32'd1);
    cyc();
    chk("memwr done", 32'(state), 32'd1);
    chk("memwr instret", 32'(instret), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
